// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder: digit type, controller states,
// and the decimal correction constants.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_ctrl_state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD adder with decimal carry and invalid-digit flag.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout,
  output logic       bad_digit
);

  logic [4:0] w_s5;

  always_comb begin
    w_s5      = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    digit     = w_s5[3:0];
    cout      = 1'b0;
    // Adding 6 skips the six unused codes; only the low nibble survives.
    if (w_s5 > {1'b0, BCD_MAX}) begin
      digit = w_s5[3:0] + BCD_ADJ;
      cout  = 1'b1;
    end
    bad_digit = (a > BCD_MAX) || (b > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit BCD add sequencer: one shared digit adder stepped LSD-first over the
// captured operands, with valid/ready handshakes on both the operand and result sides.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                carry_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry_out,
  output logic                err
);

  localparam int               CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  bcd_ctrl_state_t     r_state;
  bcd_ctrl_state_t     w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic [4*DIGITS-1:0] r_sum;
  logic                r_c;
  logic                r_cout;
  logic                r_err;

  logic [3:0]          w_a_k;
  logic [3:0]          w_b_k;
  logic [3:0]          w_digit;
  logic                w_cout;
  logic                w_bad;
  logic                w_accept;

  always_comb begin
    w_a_k = '0;
    w_b_k = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_k = r_a[4*i +: 4];
        w_b_k = r_b[4*i +: 4];
      end
    end
  end

  bcd_digit_add u_digit_add (
    .a         (w_a_k),
    .b         (w_b_k),
    .cin       (r_c),
    .digit     (w_digit),
    .cout      (w_cout),
    .bad_digit (w_bad)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_c    <= carry_in;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else if (r_state == RUN) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_cnt == CNT_W'(i)) begin
          r_sum[4*i +: 4] <= w_digit;
        end
      end
      r_c <= w_cout;
      if (w_bad) begin
        r_err <= 1'b1;
      end
      if (r_cnt == CNT_LAST) begin
        r_cout <= w_cout;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign err       = r_err;

endmodule
